sad_buffer_fill_unit: RTL and testbench
=======================================

# sad_buffer_fill_unit

Memory-side responder for the SAD buffer-load protocol that the decoder issues. It accepts the per-instruction buffer-A and buffer-B load commands and the words returned by data memory, and fills two word buffers. It raises `all_buf_flags` back to the decoder's hazard logic once both buffers are full. On an issued all-buffer instruction (abuf), it snapshots both buffers into double-buffered output registers for the SAD datapath, so the next fill can overlap.

## Interface
- `DEPTH`, default 4: words per buffer (one 4x4 byte window = 4 words); legal range 2–16.
- `DATA_W`, default 32: word width.
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `MEM_load_buff_a`  in  1  lbufa command in MEM stage; write `MEM_ReadData` into buffer A.
- `MEM_load_buff_b`  in  1  lbufb command in MEM stage; write `MEM_ReadData` into buffer B.
- `MEM_ReadData`  in  DATA_W  word returned by data memory.
- `abuf_issue`  in  1  decoder issued an abuf (all_buff decoded and not stalled).
- `all_buf_flags`  out  1  both buffers FULL; feeds the decoder stall term.
- `buf_a_count`, `buf_b_count`  out  $clog2(DEPTH+1)  current fill level.
- `snap_a`, `snap_b`  out  DEPTH*DATA_W  snapshot words; word i is at bits [i*DATA_W +: DATA_W].
- `snap_valid`  out  1  one-cycle pulse when the snapshot updates.
- `overflow_err`  out  1  sticky; a load arrived while the target buffer was FULL.
- `protocol_err`  out  1  sticky; `abuf_issue` arrived while `all_buf_flags` was 0.

## Operation
- Each buffer runs its own FSM with three states:
  - EMPTY (count 0).
  - FILLING (0 < count < DEPTH).
  - FULL (count == DEPTH).
- A load in EMPTY or FILLING:
  - writes word[count] and increments count;
  - goes to FULL when the new count equals DEPTH, otherwise to FILLING.
- A load in FULL is dropped: storage and count are unchanged and `overflow_err` is set.
- `all_buf_flags` = (A == FULL) & (B == FULL). It is decoded from registered state only, with no combinational path from any input.
- `abuf_issue` with `all_buf_flags` = 1:
  - `snap_a`/`snap_b` take the current buffer contents;
  - both FSMs return to EMPTY (count 0);
  - `snap_valid` pulses on the next cycle.
- `abuf_issue` with `all_buf_flags` = 0 is ignored apart from setting `protocol_err`. Buffers and snapshots are unchanged.
- Load on the same edge as an accepted abuf: the snapshot takes the old contents. The load is then applied to the now-empty buffer, so it writes word[0], count becomes 1, and the state is FILLING. It is not counted as overflow.
- `MEM_load_buff_a` and `MEM_load_buff_b` asserted together: both are applied independently with the same data.
- Stale storage words beyond count are never cleared. Only the snapshot is architecturally visible.

## Timing
- Load accepted at edge k: count and word visible after edge k. `all_buf_flags` rises after the edge that completes the second buffer, so the decoder releases its stall one cycle later.
- abuf accepted at edge k: `snap_*` updated and `all_buf_flags` = 0 after edge k. `snap_valid` = 1 for exactly the cycle after edge k.
- Reset values (asserted at any time, including mid-fill, takes effect immediately):
  - both FSMs EMPTY, counts 0;
  - `all_buf_flags` 0, `snap_valid` 0;
  - `snap_a`/`snap_b` all zeros;
  - both error flags 0.
  - Buffer storage need not reset.
- Throughput: one load per buffer per cycle; one abuf per cycle. Back-to-back abufs are only possible after a full refill.

## Structure
- Shared package holds the FSM state encoding (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2) and the default `DEPTH` and `DATA_W`.
- Natural sub-module: `sad_word_buffer`, instantiated twice for A and B. It contains the count, the FSM, the storage, the full flag and the overflow detect. The top level contains the snapshot registers, the abuf handshake and the error flags.

## Test plan
- Reset, then 4 A-loads 0x11..0x14 and 4 B-loads 0x21..0x24 → `all_buf_flags` rises after the 8th load edge; `buf_a_count` = `buf_b_count` = 4.
- Then `abuf_issue` → next cycle: `snap_a` = {0x14,0x13,0x12,0x11} (word 0 at LSB), `snap_valid` = 1 for one cycle, counts 0, `all_buf_flags` = 0.
- Full buffers; `abuf_issue` plus an A-load of 0xAA on the same edge → snapshot holds the old data; `buf_a_count` = 1; buffer A word0 = 0xAA; `overflow_err` = 0.
- A FULL, 5th A-load 0xFF → `overflow_err` = 1 and stays 1; the later snapshot still holds the first 4 words.
- Only B full, `abuf_issue` → `protocol_err` = 1; snapshot unchanged; `snap_valid` = 0.
- Reset asserted asynchronously after 2 A-loads → outputs zero immediately. A new fill of 4 A + 4 B words then completes normally with correct snapshot contents.

Source files
------------

// File: rtl/sad_buffer_fill_unit_pkg.sv
// Shared encodings and default sizing for the SAD buffer-fill unit.
package sad_buffer_fill_unit_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 4;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } buf_state_e;

endpackage

// File: rtl/sad_word_buffer.sv
// One load buffer: fill counter, EMPTY/FILLING/FULL FSM, word storage, overflow detect.
module sad_word_buffer
    import sad_buffer_fill_unit_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        clear,
    input  logic [DATA_W-1:0]           data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic [DEPTH*DATA_W-1:0]     words,
    output logic                        full_next_c,
    output logic                        overflow_c
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    buf_state_e        state_q, state_d;
    logic [CW-1:0]     count_d;
    logic [CW-1:0]     base_count;
    buf_state_e        base_state;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // State and fill-level register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            count   <= '0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
        end
    end

    // Next state: a clear empties first, so a same-edge load lands in word 0
    always_comb begin
        base_state  = clear ? ST_EMPTY : state_q;
        base_count  = clear ? '0 : count;
        state_d     = base_state;
        count_d     = base_count;
        wr_en       = 1'b0;
        overflow_c  = 1'b0;
        wr_idx      = base_count[IW-1:0];
        if (load) begin
            if (base_state == ST_FULL) begin
                overflow_c = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = base_count + CW'(1);
                state_d = (count_d == CW'(DEPTH)) ? ST_FULL : ST_FILLING;
            end
        end
        full_next_c = (state_d == ST_FULL);
    end

    // Word storage; stale words beyond count are never cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data;
        end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_words
        assign words[i*DATA_W +: DATA_W] = mem_q[i];
    end

endmodule

// File: rtl/sad_buffer_fill_unit.sv
// Fills buffers A and B from MEM-stage loads and snapshots both on an accepted abuf.
module sad_buffer_fill_unit
    import sad_buffer_fill_unit_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        MEM_load_buff_a,
    input  logic                        MEM_load_buff_b,
    input  logic [DATA_W-1:0]           MEM_ReadData,
    input  logic                        abuf_issue,
    output logic                        all_buf_flags,
    output logic [$clog2(DEPTH+1)-1:0]  buf_a_count,
    output logic [$clog2(DEPTH+1)-1:0]  buf_b_count,
    output logic [DEPTH*DATA_W-1:0]     snap_a,
    output logic [DEPTH*DATA_W-1:0]     snap_b,
    output logic                        snap_valid,
    output logic                        overflow_err,
    output logic                        protocol_err
);

    logic                    abuf_ok;
    logic [DEPTH*DATA_W-1:0] words_a, words_b;
    logic                    full_next_a, full_next_b;
    logic                    ovf_a, ovf_b;

    assign abuf_ok = abuf_issue & all_buf_flags;

    sad_word_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf_a (
        .clk         (Clk),
        .rst         (Reset),
        .load        (MEM_load_buff_a),
        .clear       (abuf_ok),
        .data        (MEM_ReadData),
        .count       (buf_a_count),
        .words       (words_a),
        .full_next_c (full_next_a),
        .overflow_c  (ovf_a)
    );

    sad_word_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf_b (
        .clk         (Clk),
        .rst         (Reset),
        .load        (MEM_load_buff_b),
        .clear       (abuf_ok),
        .data        (MEM_ReadData),
        .count       (buf_b_count),
        .words       (words_b),
        .full_next_c (full_next_b),
        .overflow_c  (ovf_b)
    );

    // Ready flag, snapshot registers and sticky error flags
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            all_buf_flags <= 1'b0;
            snap_a        <= '0;
            snap_b        <= '0;
            snap_valid    <= 1'b0;
            overflow_err  <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            all_buf_flags <= full_next_a & full_next_b;
            snap_valid    <= abuf_ok;
            if (abuf_ok) begin
                snap_a <= words_a;
                snap_b <= words_b;
            end
            overflow_err  <= overflow_err | ovf_a | ovf_b;
            protocol_err  <= protocol_err | (abuf_issue & ~all_buf_flags);
        end
    end

endmodule

// File: tb/tb_sad_buffer_fill_unit.sv
// Directed bench for sad_buffer_fill_unit (DEPTH=4, DATA_W=32).
module tb_sad_buffer_fill_unit;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         MEM_load_buff_a;
    logic         MEM_load_buff_b;
    logic [31:0]  MEM_ReadData;
    logic         abuf_issue;
    logic         all_buf_flags;
    logic [2:0]   buf_a_count, buf_b_count;
    logic [127:0] snap_a, snap_b;
    logic         snap_valid, overflow_err, protocol_err;

    int tests  = 0;
    int failed = 0;

    sad_buffer_fill_unit #(.DEPTH(4), .DATA_W(32)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .MEM_load_buff_a (MEM_load_buff_a),
        .MEM_load_buff_b (MEM_load_buff_b),
        .MEM_ReadData    (MEM_ReadData),
        .abuf_issue      (abuf_issue),
        .all_buf_flags   (all_buf_flags),
        .buf_a_count     (buf_a_count),
        .buf_b_count     (buf_b_count),
        .snap_a          (snap_a),
        .snap_b          (snap_b),
        .snap_valid      (snap_valid),
        .overflow_err    (overflow_err),
        .protocol_err    (protocol_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given controls held, then controls dropped; sample point is #1 after the edge
    task automatic step(input logic la, input logic lb, input logic [31:0] d, input logic ab);
        MEM_load_buff_a = la;
        MEM_load_buff_b = lb;
        MEM_ReadData    = d;
        abuf_issue      = ab;
        @(posedge Clk);
        #1;
        MEM_load_buff_a = 1'b0;
        MEM_load_buff_b = 1'b0;
        MEM_ReadData    = '0;
        abuf_issue      = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        MEM_load_buff_a = 1'b0;
        MEM_load_buff_b = 1'b0;
        MEM_ReadData    = '0;
        abuf_issue      = 1'b0;
        #12;
        chk("rst_flags",   128'(all_buf_flags), 128'd0);
        chk("rst_cnt_a",   128'(buf_a_count),   128'd0);
        chk("rst_cnt_b",   128'(buf_b_count),   128'd0);
        chk("rst_snap_a",  snap_a,              128'd0);
        chk("rst_snap_b",  snap_b,              128'd0);
        chk("rst_valid",   128'(snap_valid),    128'd0);
        chk("rst_ovf",     128'(overflow_err),  128'd0);
        chk("rst_proto",   128'(protocol_err),  128'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // First fill: A 0x11..0x14, then B 0x21..0x24
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h11 + 32'(i), 1'b0);
        chk("fill1_cnt_a", 128'(buf_a_count), 128'd4);
        chk("fill1_flag_a_only", 128'(all_buf_flags), 128'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h21 + 32'(i), 1'b0);
        chk("fill1_flag_7", 128'(all_buf_flags), 128'd0);
        step(1'b0, 1'b1, 32'h24, 1'b0);
        chk("fill1_flag_8", 128'(all_buf_flags), 128'd1);
        chk("fill1_cnt_b",  128'(buf_b_count),   128'd4);

        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("abuf1_snap_a", snap_a, 128'h00000014_00000013_00000012_00000011);
        chk("abuf1_snap_b", snap_b, 128'h00000024_00000023_00000022_00000021);
        chk("abuf1_valid",  128'(snap_valid),    128'd1);
        chk("abuf1_cnt_a",  128'(buf_a_count),   128'd0);
        chk("abuf1_cnt_b",  128'(buf_b_count),   128'd0);
        chk("abuf1_flags",  128'(all_buf_flags), 128'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("abuf1_valid_drop", 128'(snap_valid), 128'd0);

        // Simultaneous A+B loads share data
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h51 + 32'(i), 1'b0);
        chk("both_flags", 128'(all_buf_flags), 128'd1);

        // abuf with same-edge A load 0xAA
        step(1'b1, 1'b0, 32'hAA, 1'b1);
        chk("ovl_snap_a", snap_a, 128'h00000054_00000053_00000052_00000051);
        chk("ovl_snap_b", snap_b, 128'h00000054_00000053_00000052_00000051);
        chk("ovl_cnt_a",  128'(buf_a_count),   128'd1);
        chk("ovl_cnt_b",  128'(buf_b_count),   128'd0);
        chk("ovl_ovf",    128'(overflow_err),  128'd0);
        chk("ovl_flags",  128'(all_buf_flags), 128'd0);
        chk("ovl_valid",  128'(snap_valid),    128'd1);

        // Complete A, then overflow it with 0xFF
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hAB + 32'(i), 1'b0);
        chk("a_full_cnt", 128'(buf_a_count), 128'd4);
        step(1'b1, 1'b0, 32'hFF, 1'b0);
        chk("ovf_set",    128'(overflow_err), 128'd1);
        chk("ovf_cnt_a",  128'(buf_a_count),  128'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h61 + 32'(i), 1'b0);
        chk("ovf_sticky", 128'(overflow_err),  128'd1);
        chk("ovf_flags",  128'(all_buf_flags), 128'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("ovf_snap_a", snap_a, 128'h000000AD_000000AC_000000AB_000000AA);
        chk("ovf_snap_b", snap_b, 128'h00000064_00000063_00000062_00000061);
        step(1'b0, 1'b0, 32'h0, 1'b0);

        // Only B full, abuf rejected
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h71 + 32'(i), 1'b0);
        chk("proto_pre", 128'(protocol_err), 128'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("proto_set",    128'(protocol_err), 128'd1);
        chk("proto_valid",  128'(snap_valid),   128'd0);
        chk("proto_snap_a", snap_a, 128'h000000AD_000000AC_000000AB_000000AA);
        chk("proto_snap_b", snap_b, 128'h00000064_00000063_00000062_00000061);
        chk("proto_cnt_b",  128'(buf_b_count),  128'd4);

        // Two A loads, then asynchronous reset mid-cycle
        step(1'b1, 1'b0, 32'h01, 1'b0);
        step(1'b1, 1'b0, 32'h02, 1'b0);
        chk("pre_arst_cnt_a", 128'(buf_a_count), 128'd2);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_cnt_a",  128'(buf_a_count),  128'd0);
        chk("arst_cnt_b",  128'(buf_b_count),  128'd0);
        chk("arst_snap_a", snap_a,             128'd0);
        chk("arst_snap_b", snap_b,             128'd0);
        chk("arst_ovf",    128'(overflow_err), 128'd0);
        chk("arst_proto",  128'(protocol_err), 128'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Clean refill after reset
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h81 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h91 + 32'(i), 1'b0);
        chk("refill_flags", 128'(all_buf_flags), 128'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("refill_snap_a", snap_a, 128'h00000084_00000083_00000082_00000081);
        chk("refill_snap_b", snap_b, 128'h00000094_00000093_00000092_00000091);
        chk("refill_valid",  128'(snap_valid),   128'd1);
        chk("refill_ovf",    128'(overflow_err), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
